mat_result_streamer: RTL and testbench
======================================

// Module: mat_result_streamer
// PURPOSE
//  Reader side of mat_mult's result interface: on mult_done, snapshots the parallel mat_out
//  array and drains it as a row-major valid/ready element stream toward the host/DMA path.
//  Frees mat_mult for the next product while results are still being consumed.
// PARAMETERS
//  N_ROWS     4   rows of mat_out
//  N_COLUMNS  4   columns of mat_out
//  DATA_WIDTH 32  element width (matches int)
// PORTS
//  clk        in   1                              rising-edge clock
//  reset      in   1                              synchronous, active-high
//  mult_done  in   1                              from mat_mult; level, may stay high
//  mat_out    in   [N_ROWS][N_COLUMNS][DATA_WIDTH] result array, valid when mult_done high
//  out_valid  out  1                              stream element valid
//  out_ready  in   1                              downstream accept
//  out_data   out  DATA_WIDTH                     element value
//  out_row    out  $clog2(N_ROWS)                 row index of out_data
//  out_col    out  $clog2(N_COLUMNS)              column index of out_data
//  out_last   out  1                              final beat of the frame
//  busy       out  1                              high from snapshot until last beat accepted
//  overrun    out  1                              sticky: mult_done rose while busy
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0,
//   state=IDLE, snapshot cleared, mult_done edge register=0. Reset mid-frame drops the frame.
//  Trigger = rising edge of mult_done (registered previous value); a held level triggers once.
//  IDLE: on trigger at edge k, snapshot mat_out, busy=1 at k; out_valid=1 with element [0][0]
//   from k+1 (1-cycle latency). -> STREAM.
//  STREAM: beat transfers when out_valid && out_ready. While out_valid && !out_ready, out_data,
//   out_row, out_col, out_last hold stable. Order: col increments, wraps to 0 at N_COLUMNS-1
//   and row increments; out_last=1 only on [N_ROWS-1][N_COLUMNS-1]. Back-to-back ready gives
//   one beat/cycle, no bubbles.
//  Last beat accepted at edge m: out_valid=0, busy=0 at m, -> IDLE. Trigger sampled at m
//   (same cycle as last accept) is accepted: new snapshot taken, out_valid=1 again at m+1.
//  Trigger while busy (not the last-accept cycle): ignored, snapshot untouched, overrun=1
//   (cleared only by reset).
//  Arithmetic: none on data path; indices wrap modulo dimension; frame = N_ROWS*N_COLUMNS beats.
// CONFIGURATION
//  MAT_STREAM_CHECKSUM_EN defined: after element [N_ROWS-1][N_COLUMNS-1] one extra beat in state
//   CSUM carries sum of all elements mod 2^DATA_WIDTH, out_row=0, out_col=0; out_last moves to
//   this beat. Frame = N_ROWS*N_COLUMNS+1 beats. Undefined: no CSUM state, no adder logic.
// STRUCTURE
//  mat_pkg: DATA_WIDTH default, elem_t, stream_state_e {IDLE, STREAM, CSUM}.
//  Sub-module mat_idx_counter: row/col counter with advance input, wrap, and at_last output.
//  Snapshot is a flat register array; output register stage lives in the top.
// TESTING
//  1 mat1=mat2={0..15} row-major, mult_done 0->1, out_ready=1 -> 16 beats, one per cycle;
//    first 56,62,68,74; last 506 with out_last=1, out_row=3, out_col=3; busy drops on beat 16.
//  2 Same frame, out_ready toggled 1,0,0,1 repeating -> identical 16-value sequence; data,
//    indices and out_last stable on every stalled cycle.
//  3 mult_done held high 40 cycles -> exactly one frame; overrun stays 0.
//  4 Second mult_done edge at beat 5 -> frame unchanged; overrun=1 until reset.
//  5 reset asserted at beat 7 -> next cycle out_valid=0, busy=0, overrun=0; next trigger
//    restarts at [0][0]=56.
//  6 MAT_STREAM_CHECKSUM_EN, test 1 data -> 17 beats; beat 17 = 3920 (0xF50) with out_last=1;
//    beat 16 (506) has out_last=0.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared types and helpers for the mat_result_streamer slice.
package mat_pkg;

  localparam int unsigned DefaultDataWidth = 32;

  typedef logic [DefaultDataWidth-1:0] elem_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StCsum
  } stream_state_e;

  // Index width that stays legal for a dimension of 1.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major row/column counter: col advances first and wraps into the next row;
// the position after the final element wraps back to [0][0].
module mat_idx_counter
  import mat_pkg::*;
#(
  parameter int unsigned N_ROWS    = 4,
  parameter int unsigned N_COLUMNS = 4,
  localparam int unsigned RowW     = idx_w(N_ROWS),
  localparam int unsigned ColW     = idx_w(N_COLUMNS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            advance_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            at_last_o,
  output logic [RowW-1:0] nxt_row_o,
  output logic [ColW-1:0] nxt_col_o,
  output logic            nxt_last_o
);

  localparam logic [RowW-1:0] LastRow = RowW'(N_ROWS - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(N_COLUMNS - 1);

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] nxt_row;
  logic [ColW-1:0] nxt_col;

  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q;
    if (col_q == LastCol) begin
      nxt_col = '0;
      nxt_row = (row_q == LastRow) ? '0 : row_q + RowW'(1);
    end else begin
      nxt_col = col_q + ColW'(1);
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (advance_i) begin
      row_d = nxt_row;
      col_d = nxt_col;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign nxt_row_o  = nxt_row;
  assign nxt_col_o  = nxt_col;
  assign at_last_o  = (row_q == LastRow) && (col_q == LastCol);
  assign nxt_last_o = (nxt_row == LastRow) && (nxt_col == LastCol);

endmodule

// File: rtl/mat_result_streamer.sv
// Snapshots mat_out on a rising mult_done and drains it as a row-major valid/ready stream.
// Define MAT_STREAM_CHECKSUM_EN to append a modular-sum checksum beat to every frame.
module mat_result_streamer
  import mat_pkg::*;
#(
  parameter int unsigned N_ROWS     = 4,
  parameter int unsigned N_COLUMNS  = 4,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  localparam int unsigned RowW      = idx_w(N_ROWS),
  localparam int unsigned ColW      = idx_w(N_COLUMNS)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             mult_done,
  input  logic [N_ROWS-1:0][N_COLUMNS-1:0][DATA_WIDTH-1:0] mat_out,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [DATA_WIDTH-1:0]                            out_data,
  output logic [RowW-1:0]                                  out_row,
  output logic [ColW-1:0]                                  out_col,
  output logic                                             out_last,
  output logic                                             busy,
  output logic                                             overrun
);

  localparam int unsigned Numel = N_ROWS * N_COLUMNS;
  localparam int unsigned IdxW  = idx_w(Numel);

  stream_state_e          state_q, state_d;
  logic                   done_q;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]  snap_q [Numel];
  logic [DATA_WIDTH-1:0]  snap_d [Numel];

  logic                   trigger, accept, capture, finish, advance;
  logic [RowW-1:0]        cnt_row, cnt_nxt_row;
  logic [ColW-1:0]        cnt_col, cnt_nxt_col;
  logic                   cnt_at_last, cnt_nxt_last;
  logic [IdxW-1:0]        cur_idx, nxt_idx;
  logic                   cur_elem_last, nxt_elem_last;

  mat_idx_counter #(
    .N_ROWS    (N_ROWS),
    .N_COLUMNS (N_COLUMNS)
  ) u_idx (
    .clk_i      (clk),
    .reset_i    (reset),
    .advance_i  (advance),
    .row_o      (cnt_row),
    .col_o      (cnt_col),
    .at_last_o  (cnt_at_last),
    .nxt_row_o  (cnt_nxt_row),
    .nxt_col_o  (cnt_nxt_col),
    .nxt_last_o (cnt_nxt_last)
  );

  assign trigger = mult_done & ~done_q;
  assign accept  = out_valid_q & out_ready;
  assign cur_idx = IdxW'(cnt_row) * IdxW'(N_COLUMNS) + IdxW'(cnt_col);
  assign nxt_idx = IdxW'(cnt_nxt_row) * IdxW'(N_COLUMNS) + IdxW'(cnt_nxt_col);

`ifdef MAT_STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < Numel; i++) begin
      csum = csum + snap_q[i];
    end
  end

  // The checksum beat carries out_last, so no matrix element does.
  assign cur_elem_last = cnt_at_last & 1'b0;
  assign nxt_elem_last = cnt_nxt_last & 1'b0;
`else
  assign cur_elem_last = cnt_at_last;
  assign nxt_elem_last = cnt_nxt_last;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    snap_d      = snap_q;
    capture     = 1'b0;
    finish      = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      StIdle: begin
        capture = trigger;
      end
      StStream: begin
        if (!out_valid_q) begin
          // First beat of a frame: snapshot landed last cycle, present [0][0].
          out_valid_d = 1'b1;
          out_data_d  = snap_q[cur_idx];
          out_last_d  = cur_elem_last;
        end else if (accept) begin
          advance = 1'b1;
          if (!cnt_at_last) begin
            out_data_d = snap_q[nxt_idx];
            out_last_d = nxt_elem_last;
          end else begin
`ifdef MAT_STREAM_CHECKSUM_EN
            out_data_d = csum;
            out_last_d = 1'b1;
            state_d    = StCsum;
`else
            finish = 1'b1;
`endif
          end
        end
      end
`ifdef MAT_STREAM_CHECKSUM_EN
      StCsum: begin
        finish = accept;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    if (finish) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
      state_d     = StIdle;
      capture     = trigger;
    end

    if (capture) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLUMNS; c++) begin
          snap_d[r * N_COLUMNS + c] = mat_out[r][c];
        end
      end
      busy_d  = 1'b1;
      state_d = StStream;
    end

    if (trigger && busy_q && !finish) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < Numel; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      done_q      <= mult_done;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < Numel; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = cnt_row;
  assign out_col   = cnt_col;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Bench for mat_result_streamer: matrix-product model, beat scoreboard, directed scenarios.
module tb_mat_result_streamer;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int DW = 32;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         mult_done;
  logic [NR-1:0][NC-1:0][DW-1:0] mat_out;
  logic                         out_valid;
  logic                         out_ready = 1'b1;
  logic [DW-1:0]                out_data;
  logic [1:0]                   out_row;
  logic [1:0]                   out_col;
  logic                         out_last;
  logic                         busy;
  logic                         overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            a [NR][NC];
  logic [DW-1:0] prod [NR][NC];

  int         ready_mode = 0;
  int         rcyc = 0;
  logic [3:0] ready_pat = 4'b1001;  // cycle order 1,0,0,1

  mat_result_streamer #(
    .N_ROWS     (NR),
    .N_COLUMNS  (NC),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_done (mult_done),
    .mat_out   (mat_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compute_product();
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < NC; j++) begin
        int s = 0;
        for (int k = 0; k < NC; k++) s += a[i][k] * a[k][j];
        prod[i][j] = DW'(s);
      end
    end
  endtask

  task automatic drive_mat(input int offset);
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++)
        mat_out[i][j] = prod[i][j] + DW'(offset);
  endtask

  // Expected frame = what mat_out holds right now, row-major, plus optional checksum beat.
  task automatic push_frame();
    beat_t b;
    logic [DW-1:0] sum = '0;
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < NC; j++) begin
        b.data = mat_out[i][j];
        b.row  = 2'(i);
        b.col  = 2'(j);
`ifdef MAT_STREAM_CHECKSUM_EN
        b.last = 1'b0;
`else
        b.last = (i == NR - 1) && (j == NC - 1);
`endif
        sum = sum + mat_out[i][j];
        exp_q.push_back(b);
      end
    end
`ifdef MAT_STREAM_CHECKSUM_EN
    b.data = sum;
    b.row  = 2'd0;
    b.col  = 2'd0;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // Pulse mult_done for one cycle; returns just after trigger edge k.
  task automatic fire();
    @(posedge clk); #1;
    mult_done = 1'b1;
    push_frame();
    @(posedge clk); #1;
    mult_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done_in_time", 64'(n < budget), 64'd1);
  endtask

  always @(posedge clk) begin
    #1;
    rcyc++;
    if (ready_mode == 0) out_ready = 1'b1;
    else out_ready = ready_pat[rcyc % 4];
  end

  // Scoreboard: every accepted beat against the model, every stall for stability.
  logic          stalled = 1'b0;
  logic [63:0]   held;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_outputs_held", 64'({out_data, out_row, out_col, out_last}), held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0d, expected no beat", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(e.data));
          check("beat_row", 64'(out_row), 64'(e.row));
          check("beat_col", 64'(out_col), 64'(e.col));
          check("beat_last", 64'(out_last), 64'(e.last));
        end
      end
      stalled = out_valid && !out_ready;
      held    = 64'({out_data, out_row, out_col, out_last});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lit [4];
    lit = '{56, 62, 68, 74};
    reset     = 1'b1;
    mult_done = 1'b0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++)
        a[i][j] = i * NC + j;
    compute_product();
    drive_mat(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_row", 64'(out_row), 64'd0);
    check("rst_out_col", 64'(out_col), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // 1: full-rate frame with literal pins
    fire();
    check("t1_busy_at_trigger", 64'(busy), 64'd1);
    check("t1_valid_latency", 64'(out_valid), 64'd0);
    for (int i = 0; i < NR * NC; i++) begin
      @(posedge clk); #1;
      check("t1_no_bubble", 64'(out_valid), 64'd1);
      if (i < 4) check("t1_first_values", 64'(out_data), 64'(lit[i]));
      if (i == NR * NC - 1) begin
        check("t1_last_data", 64'(out_data), 64'd506);
        check("t1_last_row", 64'(out_row), 64'd3);
        check("t1_last_col", 64'(out_col), 64'd3);
`ifdef MAT_STREAM_CHECKSUM_EN
        check("t1_elem_not_last", 64'(out_last), 64'd0);
`else
        check("t1_last_flag", 64'(out_last), 64'd1);
`endif
      end
    end
`ifdef MAT_STREAM_CHECKSUM_EN
    @(posedge clk); #1;
    check("t6_csum_data", 64'(out_data), 64'd3920);
    check("t6_csum_last", 64'(out_last), 64'd1);
    check("t6_csum_row", 64'(out_row), 64'd0);
`endif
    @(posedge clk); #1;
    check("t1_busy_drop", 64'(busy), 64'd0);
    check("t1_valid_drop", 64'(out_valid), 64'd0);
    wait_done(10);

    // 2: stalled frame
    ready_mode = 1;
    fire();
    wait_done(200);
    ready_mode = 0;

    // 3: level held high triggers once
    @(posedge clk); #1;
    mult_done = 1'b1;
    push_frame();
    repeat (40) @(posedge clk);
    #1 mult_done = 1'b0;
    wait_done(50);
    repeat (5) @(posedge clk);
    #1;
    check("t3_no_overrun", 64'(overrun), 64'd0);
    check("t3_idle", 64'(out_valid), 64'd0);

    // 4: retrigger mid-frame with new data on mat_out
    fire();
    repeat (5) @(posedge clk);
    #1;
    mult_done = 1'b1;
    drive_mat(1000);
    @(posedge clk); #1;
    mult_done = 1'b0;
    check("t4_overrun_set", 64'(overrun), 64'd1);
    wait_done(50);
    drive_mat(0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_overrun_sticky", 64'(overrun), 64'd1);

    // 5: reset mid-frame
    fire();
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("t5_valid_cleared", 64'(out_valid), 64'd0);
    check("t5_busy_cleared", 64'(busy), 64'd0);
    check("t5_overrun_cleared", 64'(overrun), 64'd0);
    fire();
    @(posedge clk); #1;
    check("t5_restart_valid", 64'(out_valid), 64'd1);
    check("t5_restart_data", 64'(out_data), 64'd56);
    check("t5_restart_row", 64'(out_row), 64'd0);
    check("t5_restart_col", 64'(out_col), 64'd0);
    wait_done(50);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
